wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 28 ++
 rtl/wb_stage_regfile.sv | 58 +++++
 rtl/wb_stage.sv | 101 ++++++++++
 tb/tb_wb_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions used by the writeback stage and its register file:
// register-address width, writeback source encodings and the WB control word.
package wb_stage_pkg;

  // Register-address width (32 architectural registers).
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Writeback source select. Encoding 2'b11 is an alias of MD_F.
  typedef enum logic [1:0] {
    MD_F     = 2'b00,
    MD_MEM   = 2'b01,
    MD_SLT   = 2'b10,
    MD_F_ALT = 2'b11
  } md_e;

  // Control half of the WB pipeline register. Data words are kept separately
  // because their width is a module parameter.
  typedef struct packed {
    logic      valid;
    logic      rw;
    reg_addr_t da;
    md_e       md;
    logic      nv;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_regfile.sv
// Register file: one write port, two combinational read ports, R0 hardwired
// to zero, and a write-through bypass so a value being written this cycle is
// visible to readers in the same cycle.
module wb_stage_regfile
  import wb_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  reg_addr_t        waddr,
  input  logic [WIDTH-1:0] wdata,
  input  reg_addr_t        raddr_a,
  input  reg_addr_t        raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREG];

  // Storage: async clear of every entry; R0 and out-of-range addresses are never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0) && (int'(waddr) < NREG)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A: zero for R0, bypass on address match with the active write, else storage.
  always_comb begin
    rdata_a = '0;
    if (raddr_a == '0) begin
      rdata_a = '0;
    end else if (we && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end else if (int'(raddr_a) < NREG) begin
      rdata_a = regs[raddr_a];
    end
  end

  // Read port B: same policy as port A, evaluated independently.
  always_comb begin
    rdata_b = '0;
    if (raddr_b == '0) begin
      rdata_b = '0;
    end else if (we && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end else if (int'(raddr_b) < NREG) begin
      rdata_b = regs[raddr_b];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the EX result, selects the writeback value,
// commits it to the register file one edge later, exposes the in-flight
// writeback for forwarding, and counts retired instructions.
//
// Handshake: valid_in qualifies all EX inputs in the cycle it is high. There
// is no ready; the stage accepts every cycle. flush cancels only the
// instruction being captured on the current edge; whatever already sits in
// the WB register still commits.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] F_in,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             N_xor_V,
  input  logic             RW,
  input  reg_addr_t        DA,
  input  logic [1:0]       MD,
  input  reg_addr_t        AA,
  input  reg_addr_t        BA,
  output logic [WIDTH-1:0] A_data,
  output logic [WIDTH-1:0] B_data,
  output logic             wb_en,
  output reg_addr_t        wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [31:0]      retired
);

  wb_ctrl_t         ctrl_q;
  logic [WIDTH-1:0] f_q;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] d;
  logic [31:0]      retired_q;

  // WB pipeline register: capture every edge, flush only kills the valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      f_q    <= '0;
      mem_q  <= '0;
    end else begin
      ctrl_q.valid <= valid_in & ~flush;
      ctrl_q.rw    <= RW;
      ctrl_q.da    <= DA;
      ctrl_q.md    <= md_e'(MD);
      ctrl_q.nv    <= N_xor_V;
      f_q          <= F_in;
      mem_q        <= mem_data;
    end
  end

  // Writeback value select from the registered operands.
  always_comb begin
    d = f_q;
    case (ctrl_q.md)
      MD_MEM:  d = mem_q;
      MD_SLT:  d = {{(WIDTH-1){1'b0}}, ctrl_q.nv};
      default: d = f_q;
    endcase
  end

  // Writeback enable: a valid, writing instruction that does not target R0.
  always_comb begin
    wb_en   = ctrl_q.valid & ctrl_q.rw & (ctrl_q.da != '0);
    wb_addr = ctrl_q.da;
    wb_data = d;
  end

  // Retired counter: every valid instruction leaving WB counts, write or not; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (ctrl_q.valid) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

  wb_stage_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (AA),
    .raddr_b (BA),
    .rdata_a (A_data),
    .rdata_b (B_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: linear sequence of hand-computed vectors,
// each checked with an immediate assertion.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        flush;
  logic [31:0] F_in;
  logic [31:0] mem_data;
  logic        N_xor_V;
  logic        RW;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic [4:0]  AA;
  logic [4:0]  BA;
  logic [31:0] A_data;
  logic [31:0] B_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired;

  int vectors;
  int miscompares;

  wb_stage #(.WIDTH(32), .NREG(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .flush    (flush),
    .F_in     (F_in),
    .mem_data (mem_data),
    .N_xor_V  (N_xor_V),
    .RW       (RW),
    .DA       (DA),
    .MD       (MD),
    .AA       (AA),
    .BA       (BA),
    .A_data   (A_data),
    .B_data   (B_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .retired  (retired)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one EX-stage instruction (or bubble when v=0).
  task automatic drive(input logic v, input logic fl, input logic rw,
                       input logic [4:0] da, input logic [1:0] md,
                       input logic [31:0] f, input logic [31:0] m,
                       input logic nv);
    valid_in = v;
    flush    = fl;
    RW       = rw;
    DA       = da;
    MD       = md;
    F_in     = f;
    mem_data = m;
    N_xor_V  = nv;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    AA = 5'd3;
    BA = 5'd4;

    // Reset state
    #2;
    check("rst_wb_en",   {31'd0, wb_en}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_a_data",  A_data, 32'd0);
    check("rst_b_data",  B_data, 32'd0);
    check("rst_retired", retired, 32'd0);
    #10;
    reset = 1'b0;

    // Basic ALU writeback with bypass, then commit
    drive(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 32'd30, 32'd0, 1'b0);
    tick();
    check("alu_wb_en",   {31'd0, wb_en}, 32'd1);
    check("alu_wb_addr", {27'd0, wb_addr}, 32'd3);
    check("alu_wb_data", wb_data, 32'd30);
    check("alu_bypass",  A_data, 32'd30);
    check("alu_ret0",    retired, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("alu_r3",      A_data, 32'd30);
    check("alu_wb_off",  {31'd0, wb_en}, 32'd0);
    check("alu_ret1",    retired, 32'd1);

    // Memory and set-less-than sources
    drive(1'b1, 1'b0, 1'b1, 5'd4, 2'b01, 32'd99, 32'd6, 1'b0);
    tick();
    check("mem_wb_data", wb_data, 32'd6);
    drive(1'b1, 1'b0, 1'b1, 5'd5, 2'b10, 32'd99, 32'd77, 1'b1);
    tick();
    check("slt1_wb_data", wb_data, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    AA = 5'd5;
    BA = 5'd4;
    #1;
    check("slt1_r5", A_data, 32'd1);
    check("mem_r4",  B_data, 32'd6);
    drive(1'b1, 1'b0, 1'b1, 5'd5, 2'b10, 32'd99, 32'd77, 1'b0);
    tick();
    check("slt0_wb_data", wb_data, 32'd0);
    check("slt0_bypass",  A_data, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("slt0_r5",  A_data, 32'd0);
    check("src_ret4", retired, 32'd4);

    // Write to R0 is suppressed but still retires
    AA = 5'd0;
    drive(1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 32'hDEADBEEF, 32'd0, 1'b0);
    tick();
    check("r0_wb_en",   {31'd0, wb_en}, 32'd0);
    check("r0_wb_data", wb_data, 32'hDEADBEEF);
    check("r0_read",    A_data, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("r0_read2", A_data, 32'd0);
    check("r0_ret5",  retired, 32'd5);

    // Flush kills the capture only; prior instruction still commits
    AA = 5'd8;
    BA = 5'd6;
    drive(1'b1, 1'b0, 1'b1, 5'd8, 2'b00, 32'd55, 32'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd6, 2'b00, 32'd7, 32'd0, 1'b0);
    tick();
    check("fl_wb_en", {31'd0, wb_en}, 32'd0);
    check("fl_r8",    A_data, 32'd55);
    check("fl_ret6",  retired, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("fl_r6",     B_data, 32'd0);
    check("fl_ret6b",  retired, 32'd6);

    // Back-to-back writes to R7
    AA = 5'd7;
    BA = 5'd7;
    drive(1'b1, 1'b0, 1'b1, 5'd7, 2'b00, 32'd10, 32'd0, 1'b0);
    tick();
    check("b2b_a10", A_data, 32'd10);
    check("b2b_b10", B_data, 32'd10);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 2'b00, 32'd20, 32'd0, 1'b0);
    tick();
    check("b2b_a20", A_data, 32'd20);
    check("b2b_b20", B_data, 32'd20);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("b2b_r7",   A_data, 32'd20);
    check("b2b_ret8", retired, 32'd8);

    // Retired counter wrap: preload near the top with a valid instruction in WB
    drive(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    #1;
    check("wrap_pre", retired, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("wrap_zero", retired, 32'd0);

    // Reset mid-operation drops the in-flight write
    AA = 5'd9;
    BA = 5'd3;
    drive(1'b1, 1'b0, 1'b1, 5'd9, 2'b00, 32'h77, 32'd0, 1'b0);
    tick();
    check("mid_wb_en_pre", {31'd0, wb_en}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check("mid_wb_en",   {31'd0, wb_en}, 32'd0);
    check("mid_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("mid_wb_data", wb_data, 32'd0);
    check("mid_a_data",  A_data, 32'd0);
    check("mid_b_data",  B_data, 32'd0);
    check("mid_retired", retired, 32'd0);
    #3;
    reset = 1'b0;
    tick();
    check("mid_r9",      A_data, 32'd0);
    check("mid_ret_post", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
